// File: rtl/trace_pkg.sv
// Shared types for the commit trace path: one buffered retirement entry.
// The PC field exists only when TRACE_PC_EN is defined.
package trace_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
`ifdef TRACE_PC_EN
        logic [31:0] pc;
`endif
    } trace_entry_t;

endpackage

// File: rtl/commit_trace_emitter_if.sv
// Retire-side and trace-side signal bundle of commit_trace_emitter.
// The PC fields exist only when TRACE_PC_EN is defined.
interface commit_trace_emitter_if #(
    parameter int DEPTH = 8
);
    logic                     retire_valid0;
    logic                     retire_valid1;
    logic                     retire_wen0;
    logic                     retire_wen1;
    logic [4:0]               retire_wnum0;
    logic [4:0]               retire_wnum1;
    logic [31:0]              retire_wdata0;
    logic [31:0]              retire_wdata1;
    logic                     retire_ready;
    logic                     trace_ready;
    logic                     cmt_valid0;
    logic                     cmt_valid1;
    logic                     rf_wen_0;
    logic                     rf_wen_1;
    logic [4:0]               debug0_wb_rf_wnum;
    logic [4:0]               debug1_wb_rf_wnum;
    logic [31:0]              debug0_wb_rf_wdata;
    logic [31:0]              debug1_wb_rf_wdata;
    logic [$clog2(DEPTH):0]   occupancy;
`ifdef TRACE_PC_EN
    logic [31:0]              retire_pc0;
    logic [31:0]              retire_pc1;
    logic [31:0]              debug0_wb_pc;
    logic [31:0]              debug1_wb_pc;
`endif

    // Emitter side: consumes retirements, produces the trace.
    modport slave (
        input  retire_valid0, retire_valid1, retire_wen0, retire_wen1,
        input  retire_wnum0, retire_wnum1, retire_wdata0, retire_wdata1,
        input  trace_ready,
`ifdef TRACE_PC_EN
        input  retire_pc0, retire_pc1,
        output debug0_wb_pc, debug1_wb_pc,
`endif
        output retire_ready, cmt_valid0, cmt_valid1, rf_wen_0, rf_wen_1,
        output debug0_wb_rf_wnum, debug1_wb_rf_wnum,
        output debug0_wb_rf_wdata, debug1_wb_rf_wdata, occupancy
    );

    // Surrounding system: ROB driving retirements, sink accepting the trace.
    modport master (
        output retire_valid0, retire_valid1, retire_wen0, retire_wen1,
        output retire_wnum0, retire_wnum1, retire_wdata0, retire_wdata1,
        output trace_ready,
`ifdef TRACE_PC_EN
        output retire_pc0, retire_pc1,
        input  debug0_wb_pc, debug1_wb_pc,
`endif
        input  retire_ready, cmt_valid0, cmt_valid1, rf_wen_0, rf_wen_1,
        input  debug0_wb_rf_wnum, debug1_wb_rf_wnum,
        input  debug0_wb_rf_wdata, debug1_wb_rf_wdata, occupancy
    );

endinterface

// File: rtl/commit_trace_emitter.sv
// In-order retirement buffer presenting a dual-slot commit trace on valid/ready.
// Optional PC tracing is enabled by defining TRACE_PC_EN.
module commit_trace_emitter
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic                   aclk,
    input logic                   aresetn,
    commit_trace_emitter_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [CNT_W-1:0] count;

    trace_entry_t     mem [DEPTH];
    trace_entry_t     slot0_entry;
    trace_entry_t     slot1_entry;
    trace_entry_t     first_entry;
    trace_entry_t     head;
    trace_entry_t     head_p1;

    logic             ready;
    logic             valid0;
    logic             valid1;
    logic [1:0]       enq_n;
    logic [1:0]       deq_n;

    assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

    // Depends on registered count only, so trace_ready never reaches it.
    assign ready  = (count <= READY_MAX);
    assign valid0 = (count != '0);
    assign valid1 = (count > CNT_W'(1));

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        slot0_entry       = '0;
        slot0_entry.wen   = bus.retire_wen0 && (bus.retire_wnum0 != REG_ZERO);
        slot0_entry.wnum  = bus.retire_wnum0;
        slot0_entry.wdata = bus.retire_wdata0;
        slot1_entry       = '0;
        slot1_entry.wen   = bus.retire_wen1 && (bus.retire_wnum1 != REG_ZERO);
        slot1_entry.wnum  = bus.retire_wnum1;
        slot1_entry.wdata = bus.retire_wdata1;
`ifdef TRACE_PC_EN
        slot0_entry.pc    = bus.retire_pc0;
        slot1_entry.pc    = bus.retire_pc1;
`endif
        // A lone slot 1 is compacted into the next single entry.
        first_entry = bus.retire_valid0 ? slot0_entry : slot1_entry;
        enq_n = ready ? (2'(bus.retire_valid0) + 2'(bus.retire_valid1)) : 2'd0;
        deq_n = bus.trace_ready ? {valid1, valid0 & ~valid1} : 2'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(enq_n);
            rd_ptr <= rd_ptr + PTR_W'(deq_n);
            count  <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    // NOTE: storage is not reset; count gates every output, so stale
    // contents are never visible and the array maps to plain RAM.
    always_ff @(posedge aclk) begin
        if (enq_n != 2'd0) mem[wr_ptr] <= first_entry;
        if (enq_n == 2'd2) mem[wr_ptr_p1] <= slot1_entry;
    end

    assign head    = mem[rd_ptr];
    assign head_p1 = mem[rd_ptr_p1];

    always_comb begin
        bus.retire_ready       = ready;
        bus.occupancy          = count;
        bus.cmt_valid0         = valid0;
        bus.cmt_valid1         = valid1;
        bus.rf_wen_0           = valid0 & head.wen;
        bus.rf_wen_1           = valid1 & head_p1.wen;
        bus.debug0_wb_rf_wnum  = valid0 ? head.wnum    : '0;
        bus.debug1_wb_rf_wnum  = valid1 ? head_p1.wnum : '0;
        bus.debug0_wb_rf_wdata = valid0 ? head.wdata    : '0;
        bus.debug1_wb_rf_wdata = valid1 ? head_p1.wdata : '0;
`ifdef TRACE_PC_EN
        bus.debug0_wb_pc       = valid0 ? head.pc    : '0;
        bus.debug1_wb_pc       = valid1 ? head_p1.pc : '0;
`endif
    end

endmodule

// File: tb/tb_commit_trace_emitter.sv
// Directed plus randomized bench for commit_trace_emitter against a queue model.
// Works with or without TRACE_PC_EN defined.
module tb_commit_trace_emitter;
    import trace_pkg::*;

    localparam int DEPTH = 8;

    logic aclk = 1'b0;
    logic aresetn;
    int   n_cmp  = 0;
    int   n_fail = 0;

    trace_entry_t model_q[$];

    commit_trace_emitter_if #(.DEPTH(DEPTH)) bus ();

    commit_trace_emitter #(.DEPTH(DEPTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected trace derived from the model queue: head on slot 0, next on slot 1.
    task automatic check_outputs();
        trace_entry_t e0 = '0;
        trace_entry_t e1 = '0;
        int sz = model_q.size();
        if (sz >= 1) e0 = model_q[0];
        if (sz >= 2) e1 = model_q[1];
        check("retire_ready", bus.retire_ready, 32'((DEPTH - sz) >= 2));
        check("occupancy",    32'(bus.occupancy), 32'(sz));
        check("cmt_valid0",   bus.cmt_valid0, 32'(sz >= 1));
        check("cmt_valid1",   bus.cmt_valid1, 32'(sz >= 2));
        check("rf_wen_0",     bus.rf_wen_0, 32'(e0.wen));
        check("rf_wen_1",     bus.rf_wen_1, 32'(e1.wen));
        check("wnum0",        32'(bus.debug0_wb_rf_wnum), 32'(e0.wnum));
        check("wnum1",        32'(bus.debug1_wb_rf_wnum), 32'(e1.wnum));
        check("wdata0",       bus.debug0_wb_rf_wdata, e0.wdata);
        check("wdata1",       bus.debug1_wb_rf_wdata, e1.wdata);
`ifdef TRACE_PC_EN
        check("pc0",          bus.debug0_wb_pc, e0.pc);
        check("pc1",          bus.debug1_wb_pc, e1.pc);
`endif
    endtask

    task automatic drive(input bit v0, input bit w0, input logic [4:0] n0, input logic [31:0] d0,
                         input bit v1, input bit w1, input logic [4:0] n1, input logic [31:0] d1);
        bus.retire_valid0 = v0;
        bus.retire_wen0   = w0;
        bus.retire_wnum0  = n0;
        bus.retire_wdata0 = d0;
        bus.retire_valid1 = v1;
        bus.retire_wen1   = w1;
        bus.retire_wnum1  = n1;
        bus.retire_wdata1 = d1;
`ifdef TRACE_PC_EN
        bus.retire_pc0    = $urandom;
        bus.retire_pc1    = $urandom;
`endif
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    endtask

    // One clock: check at negedge, then advance the model at the posedge.
    task automatic cycle();
        trace_entry_t e0 = '0;
        trace_entry_t e1 = '0;
        bit v0, v1, rdy;
        int deq;
        @(negedge aclk);
        check_outputs();
        v0 = bus.retire_valid0;
        v1 = bus.retire_valid1;
        e0.wen   = bus.retire_wen0 && (bus.retire_wnum0 != 5'd0);
        e0.wnum  = bus.retire_wnum0;
        e0.wdata = bus.retire_wdata0;
        e1.wen   = bus.retire_wen1 && (bus.retire_wnum1 != 5'd0);
        e1.wnum  = bus.retire_wnum1;
        e1.wdata = bus.retire_wdata1;
`ifdef TRACE_PC_EN
        e0.pc    = bus.retire_pc0;
        e1.pc    = bus.retire_pc1;
`endif
        rdy = (DEPTH - model_q.size()) >= 2;
        deq = bus.trace_ready ? ((model_q.size() >= 2) ? 2 : model_q.size()) : 0;
        @(posedge aclk);
        repeat (deq) void'(model_q.pop_front());
        if (rdy && v0) model_q.push_back(e0);
        if (rdy && v1) model_q.push_back(e1);
        #1;
    endtask

    task automatic random_dual();
        drive(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    endtask

    initial begin
        aresetn = 1'b0;
        bus.trace_ready = 1'b0;
        idle();
        repeat (2) @(posedge aclk);
        #1;
        check_outputs();
        aresetn = 1'b1;

        // Dual retire, presented next cycle, drained the one after.
        bus.trace_ready = 1'b1;
        drive(1, 1, 5'd3, 32'h11, 1, 1, 5'd5, 32'h22);
        cycle();
        check("dual_valid0", bus.cmt_valid0, 32'd1);
        check("dual_valid1", bus.cmt_valid1, 32'd1);
        check("dual_wnum0", 32'(bus.debug0_wb_rf_wnum), 32'd3);
        check("dual_wnum1", 32'(bus.debug1_wb_rf_wnum), 32'd5);
        check("dual_wdata0", bus.debug0_wb_rf_wdata, 32'h11);
        check("dual_wdata1", bus.debug1_wb_rf_wdata, 32'h22);
        idle();
        cycle();
        check("dual_drained", 32'(bus.occupancy), 32'd0);

        // Lone slot-1 retirement lands on trace slot 0.
        drive(0, 0, 5'd0, 32'd0, 1, 1, 5'd7, 32'hAB);
        cycle();
        check("lone_valid0", bus.cmt_valid0, 32'd1);
        check("lone_valid1", bus.cmt_valid1, 32'd0);
        check("lone_wnum0", 32'(bus.debug0_wb_rf_wnum), 32'd7);
        check("lone_wdata0", bus.debug0_wb_rf_wdata, 32'hAB);
        idle();
        cycle();

        // Write to r0 keeps data but drops the write enable.
        drive(1, 1, 5'd0, 32'hDEAD, 0, 0, 5'd0, 32'd0);
        cycle();
        check("r0_valid0", bus.cmt_valid0, 32'd1);
        check("r0_wen0", bus.rf_wen_0, 32'd0);
        check("r0_wdata0", bus.debug0_wb_rf_wdata, 32'hDEAD);
        idle();
        cycle();

        // Fill with the sink stalled; the fifth dual retire must be ignored.
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 5'(2 * i + 1), 32'(32'h100 + i), 1, 1, 5'(2 * i + 2), 32'(32'h200 + i));
            cycle();
            if (i == 3) begin
                check("fill_occ8", 32'(bus.occupancy), 32'd8);
                check("fill_not_ready", bus.retire_ready, 32'd0);
            end
        end
        check("fill_hold_occ8", 32'(bus.occupancy), 32'd8);
        idle();
        bus.trace_ready = 1'b1;
        repeat (4) cycle();
        check("drain_empty", 32'(bus.occupancy), 32'd0);

        // Three fill/drain rounds walk the pointers around the ring.
        for (int r = 0; r < 3; r++) begin
            bus.trace_ready = 1'b0;
            repeat (4) begin
                random_dual();
                cycle();
            end
            idle();
            bus.trace_ready = 1'b1;
            repeat (4) cycle();
        end
        check("rounds_empty", 32'(bus.occupancy), 32'd0);

        // Mixed random traffic with random sink stalls.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            bus.trace_ready = ($urandom_range(0, 9) < 6);
            cycle();
        end

        // Drain, then hold five entries and pulse reset mid-cycle.
        idle();
        bus.trace_ready = 1'b1;
        repeat (5) cycle();
        bus.trace_ready = 1'b0;
        random_dual();
        cycle();
        random_dual();
        cycle();
        drive(1, 1, 5'd9, 32'h99, 0, 0, 5'd0, 32'd0);
        cycle();
        check("pre_reset_occ5", 32'(bus.occupancy), 32'd5);
        idle();
        #2;
        aresetn = 1'b0;
        model_q.delete();
        #1;
        check_outputs();
        repeat (2) @(posedge aclk);
        #1;
        check_outputs();
        aresetn = 1'b1;
        bus.trace_ready = 1'b1;
        repeat (3) cycle();
        drive(1, 1, 5'd4, 32'h44, 1, 1, 5'd6, 32'h66);
        cycle();
        idle();
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_emitter.md
# commit_trace_emitter

Buffers in-order instruction retirements from the reorder buffer and presents them as a dual-slot commit trace on a valid/ready handshake. The trace feeds the architectural (logic) register-file mirror and the difftest port. Each slot carries commit-valid, register-write enable, destination number and write data. The block decouples retire bandwidth from trace-sink stalls without ever reordering or dropping a retirement.

## Interface
Parameters:
- DEPTH, 8, number of retirement entries buffered; power of two, ≥ 4.

Ports (one clock; reset is asynchronous and active-low):
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- retire_valid0 / retire_valid1  input  1  ROB retire slot valid (slot 0 older)
- retire_wen0 / retire_wen1  input  1  slot writes a GPR
- retire_wnum0 / retire_wnum1  input  5  destination register
- retire_wdata0 / retire_wdata1  input  32  write data
- retire_pc0 / retire_pc1  input  32  retiring PC (TRACE_PC_EN only)
- retire_ready  output  1  buffer accepts two entries this cycle
- trace_ready  input  1  sink consumes presented slots this cycle
- cmt_valid0 / cmt_valid1  output  1  trace slot valid
- rf_wen_0 / rf_wen_1  output  1  trace slot register write
- debug0_wb_rf_wnum / debug1_wb_rf_wnum  output  5  trace destination
- debug0_wb_rf_wdata / debug1_wb_rf_wdata  output  32  trace data
- debug0_wb_pc / debug1_wb_pc  output  32  trace PC (TRACE_PC_EN only)
- occupancy  output  $clog2(DEPTH)+1  entries currently held

## Operation
- Circular buffer of DEPTH entries. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is one bit wider.
- Enqueue fires when retire_ready is high and at least one retire_valid is high.
  - If both slots are valid: slot 0 goes in first, then slot 1.
  - If only one slot is valid (including a lone slot 1): it is compacted into the next single entry.
- retire_ready = (DEPTH − count) ≥ 2. The ROB holds retirement while low. Valid retire inputs arriving while retire_ready is low are ignored, not an error.
- Stored wen is forced to 0 when wnum == 0; the wdata is kept.
- Presentation:
  - cmt_valid0 = count ≥ 1, showing the head entry.
  - cmt_valid1 = count ≥ 2, showing head+1.
  - cmt_valid1 is never high without cmt_valid0.
- rf_wen_x, wnum and wdata are driven from the buffer storage. When a slot is not valid they are driven 0.
- Dequeue fires on trace_ready and removes 1 or 2 entries: every valid slot presented that cycle.
- Simultaneous enqueue and dequeue in one cycle:
  - count_next = count + enq_n − deq_n.
  - Enqueue uses the write pointer; dequeue uses the read pointer.
- Full: count == DEPTH gives retire_ready = 0. With count == DEPTH−1, retire_ready is also 0.
- Empty: both cmt_valid are 0 and trace_ready has no effect.

## Timing
- Reset (async assert, synchronous deassert handled upstream): pointers, count and occupancy go to 0. All cmt_valid, rf_wen, wnum, wdata and pc outputs are 0. retire_ready is 1.
- Reset asserted mid-operation discards every buffered entry immediately.
- Latency: an entry enqueued at edge t is presented from cycle t+1 at the earliest. There is no combinational path from retire inputs to trace outputs.
- retire_ready depends only on registered count. There is no path from trace_ready to retire_ready within a cycle.
- Throughput: 2 entries/cycle sustained when trace_ready stays high.

## Configuration
- TRACE_PC_EN defined: a PC field is stored per entry, and retire_pc0/1 plus debug0_wb_pc/debug1_wb_pc exist, following the same ordering and zeroing rules.
- TRACE_PC_EN not defined: those ports and the PC storage are absent. Behaviour is otherwise identical.

## Structure
- Shared package `trace_pkg` holds:
  - `trace_entry_t` struct: wen, wnum[4:0], wdata[31:0], and pc[31:0] under TRACE_PC_EN.
  - the REG_ZERO constant (5'd0).
- Single module with no sub-module. The storage array and pointer/count logic are inline.

## Test plan
- Reset then idle → retire_ready=1, cmt_valid0/1=0, occupancy=0.
- Dual retire {r3←0x11, r5←0x22}, trace_ready=1 → next cycle cmt_valid0/1=1, wnum 3/5, wdata 0x11/0x22. Occupancy goes to 0 the following cycle.
- Lone slot-1 retire r7←0xAB → presented on slot 0 (debug0 wnum=7), cmt_valid1=0.
- Retire r0←0xDEAD with wen=1 → cmt_valid0=1, rf_wen_0=0.
- trace_ready=0 for 5 dual retires (DEPTH=8) → retire_ready drops after the 4th (occupancy 8).
  - Releasing trace_ready drains in order 2 per cycle.
  - Buffer wraps without loss across 3 fill/drain rounds.
- aresetn pulsed low with 5 entries held → all outputs 0 immediately; no stale entry appears after release.
